logic_resp: RTL and testbench
=============================

Name: logic_resp

Overview:
- DUT-side responder for the bench's operand interface: accepts operand pairs (a, b) plus an opcode over a valid/ready request channel.
- Computes a 4-bit bitwise result and returns it over a valid/ready response channel.
- Buffers up to DEPTH outstanding results so the bench driver and monitor can run decoupled.
- Sits directly under tb, connected through the operand/result interface signals.

Parameters:
- WIDTH, 4, operand and result width in bits.
- DEPTH, 4, result buffer entries; power of two, at least 2.
- TAG_W, 8, width of the per-transaction sequence tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- req_op  in  2  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  WIDTH  result.
- rsp_op  out  2  echoed opcode.
- rsp_tag  out  TAG_W  sequence number of the request that produced this result.
- level  out  $clog2(DEPTH)+1  number of buffered results.

Behaviour:
- Reset (async assert, sync deassert by the system): buffer emptied, pointers 0, tag counter 0, level 0, rsp_valid 0, rsp_y/rsp_op/rsp_tag 0, req_ready 1 after reset releases.
- Accept: handshake when req_valid && req_ready on a rising edge. The result is computed combinationally from req_a/req_b/req_op and written into the buffer that edge, together with req_op and the current tag.
- Tag counter increments by 1 per accepted request and wraps from 2^TAG_W-1 to 0.
- Opcode results:
  - AND: a&b
  - OR: a|b
  - XOR: a^b
  - NAND: ~(a&b)
  - All results are WIDTH bits with no extension.
- Latency: a result accepted at edge N is visible on rsp_* with rsp_valid=1 after edge N when the buffer was empty. There is no same-cycle combinational path from req to rsp.
- Response: rsp_y/rsp_op/rsp_tag are driven from the buffer head (registered or read-registered) and stay stable while rsp_valid && !rsp_ready. The entry pops on rsp_valid && rsp_ready.
- Ordering: strict FIFO; responses come out in request order.
- req_ready = (level < DEPTH). Full-state push is only allowed when not full; there is no pass-through when full, even if a pop happens the same cycle.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Simultaneous push and pop at level 0 is impossible (rsp_valid=0), so level goes to 1.
- Pointers wrap modulo DEPTH. Level is an extra-bit counter: full when level==DEPTH, empty when level==0.
- req_valid without req_ready: no state change; the bench must hold the request stable.
- Reset mid-operation: all buffered results discarded immediately and rsp_valid drops asynchronously with rst_n. No partial transfer completes.
- Inputs with X during req_valid=0 are ignored.

Decomposition:
- Package logic_resp_pkg:
  - typedef enum logic [1:0] op_t {OP_AND, OP_OR, OP_XOR, OP_NAND}.
  - Default WIDTH/DEPTH/TAG_W constants.
  - Function calc(op_t, a, b) shared by RTL and the bench scoreboard.
- Sub-module logic_resp_fifo:
  - Synchronous FIFO, parameterised by data width and DEPTH.
  - Provides push/pop/full/empty/level.
  - Stores {op, tag, y}.
- Top level holds the tag counter, the opcode decode and the handshake glue.

Test Plan:
- Single op: a=4'b0100, b=4'b1100, op=AND, rsp_ready=1 → one cycle later rsp_valid=1, rsp_y=4'b0100, rsp_tag=0, rsp_op=0.
- All opcodes: a=4'b1010, b=4'b0110 for ops 0..3 → y = 0010, 1110, 1100, 1101 with tags 0,1,2,3 in order.
- Backpressure/full: rsp_ready=0, push 5 requests back-to-back → first 4 accepted, req_ready=0 from the cycle after the 4th, level=4. rsp_* held stable. Raise rsp_ready → 4 results drain in order and req_ready returns to 1 after the first pop.
- Simultaneous push/pop at level=2: one cycle with both handshakes → level stays 2 and the correct head advances.
- Tag wrap: 256 accepted requests → the 257th response carries rsp_tag=0.
- Reset mid-stream: level=3, assert rst_n=0 between edges → rsp_valid=0 and level=0 immediately. After release the next request returns tag=0.

Source files
------------

// File: rtl/logic_resp_pkg.sv
// Shared types, default sizes and the bitwise operation used by the responder
// and its scoreboard.
package logic_resp_pkg;

   localparam int WIDTH_D = 4;
   localparam int DEPTH_D = 4;
   localparam int TAG_W_D = 8;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_t;

   // One result bit; callers apply it per bit so any operand width works.
   function automatic logic calc(op_t op, logic a, logic b);
      logic r;
      r = 1'b0;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_resp_fifo.sv
// Synchronous FIFO with an extra-bit level counter; head entry is read
// straight from the storage registers.
module logic_resp_fifo #(
   parameter int DW    = 14,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [DW-1:0]          wdata,
   input  logic                   pop,
   output logic [DW-1:0]          rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push into a full buffer is refused even if the head pops this edge.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/logic_resp.sv
// Operand responder: computes a bitwise result per accepted request and
// returns it in order, tagged with the request's sequence number.
module logic_resp
   import logic_resp_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int DEPTH = DEPTH_D,
   parameter int TAG_W = TAG_W_D
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WIDTH-1:0]       req_a,
   input  logic [WIDTH-1:0]       req_b,
   input  logic [1:0]             req_op,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_y,
   output logic [1:0]             rsp_op,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic [$clog2(DEPTH):0] level
);

   localparam int DW = 2 + TAG_W + WIDTH;

   // Both channels use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; the sender holds its payload until then.
   logic             accept;
   logic             pop;
   logic             full;
   logic             empty;
   logic [TAG_W-1:0] tag;
   logic [WIDTH-1:0] y;
   logic [DW-1:0]    wdata;
   logic [DW-1:0]    rdata;
   op_t              op_in;

   assign op_in     = op_t'(req_op);
   assign req_ready = !full;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = !empty;
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y[i] = calc(op_in, req_a[i], req_b[i]);
      end
   end

   assign wdata = {req_op, tag, y};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag <= '0;
      end else if (accept) begin
         tag <= tag + 1'b1;
      end
   end

   logic_resp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign rsp_op  = rdata[DW-1 -: 2];
   assign rsp_tag = rdata[WIDTH +: TAG_W];
   assign rsp_y   = rdata[WIDTH-1:0];

endmodule

// File: tb/tb_logic_resp.sv
// Bench for logic_resp: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_logic_resp;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int TAG_W = 8;
   localparam int W     = 2 + TAG_W + WIDTH;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [1:0]       req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_y;
   logic [1:0]       rsp_op;
   logic [TAG_W-1:0] rsp_tag;
   logic [2:0]       level;

   logic_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_op    (rsp_op),
      .rsp_tag   (rsp_tag),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]     exp_q[$];
   logic [TAG_W-1:0] m_tag;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      logic [3:0] y;
   } vec_t;

   vec_t tbl[5];

   // Truth table per opcode, indexed by {a_bit, b_bit}.
   function automatic logic [WIDTH-1:0] ref_y(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                              logic [1:0] op);
      logic [3:0] lut [4];
      logic [WIDTH-1:0] r;
      lut[0] = 4'b1000;
      lut[1] = 4'b1110;
      lut[2] = 4'b0110;
      lut[3] = 4'b0111;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = lut[op][{a[i], b[i]}];
      end
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      check("level", 32'(level), 32'(exp_q.size()));
      check("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         check("rsp_word", 32'({rsp_op, rsp_tag, rsp_y}), 32'(exp_q[0]));
      end
   endtask

   // Called at posedge+1: drives one cycle of traffic, advances the model.
   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic r);
      logic acc;
      logic popd;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      rsp_ready = r;
      acc  = v && (exp_q.size() < DEPTH);
      popd = r && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (popd) void'(exp_q.pop_front());
      if (acc) begin
         exp_q.push_back({op, m_tag, ref_y(a, b, op)});
         m_tag = m_tag + 1'b1;
      end
      req_valid = 1'b0;
      check_state();
   endtask

   task automatic rand_step(input logic v, input logic r);
      step(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), r);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      exp_q.delete();
      m_tag = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{a: 4'b0100, b: 4'b1100, op: 2'd0, y: 4'b0100};
      tbl[1] = '{a: 4'b1010, b: 4'b0110, op: 2'd0, y: 4'b0010};
      tbl[2] = '{a: 4'b1010, b: 4'b0110, op: 2'd1, y: 4'b1110};
      tbl[3] = '{a: 4'b1010, b: 4'b0110, op: 2'd2, y: 4'b1100};
      tbl[4] = '{a: 4'b1010, b: 4'b0110, op: 2'd3, y: 4'b1101};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      m_tag     = '0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rsp_y", 32'(rsp_y), 32'd0);
      check("rst_rsp_op", 32'(rsp_op), 32'd0);
      check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;

      // Vector table: each result appears one edge after its request.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
         check("tbl_valid", 32'(rsp_valid), 32'd1);
         check("tbl_y", 32'(rsp_y), 32'(tbl[i].y));
         check("tbl_op", 32'(rsp_op), 32'(tbl[i].op));
         check("tbl_tag", 32'(rsp_tag), 32'(i));
      end
      step(1'b0, '0, '0, 2'd0, 1'b1);
      check("tbl_drained", 32'(rsp_valid), 32'd0);

      // Backpressure: five requests, only four fit.
      for (int i = 0; i < 5; i++) rand_step(1'b1, 1'b0);
      check("full_level", 32'(level), 32'd4);
      check("full_ready", 32'(req_ready), 32'd0);
      rand_step(1'b0, 1'b0);
      rand_step(1'b0, 1'b0);
      rand_step(1'b0, 1'b1);
      check("ready_after_pop", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b1);
      check("full_drained", 32'(level), 32'd0);

      // Simultaneous push and pop at level 2.
      rand_step(1'b1, 1'b0);
      rand_step(1'b1, 1'b0);
      rand_step(1'b1, 1'b1);
      check("pushpop_level", 32'(level), 32'd2);
      rand_step(1'b0, 1'b1);
      rand_step(1'b0, 1'b1);

      // Reset with three results buffered.
      for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0);
      check("pre_rst_level", 32'(level), 32'd3);
      rst_n = 1'b0;
      #1;
      check("async_rsp_valid", 32'(rsp_valid), 32'd0);
      check("async_level", 32'(level), 32'd0);
      exp_q.delete();
      m_tag = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rand_step(1'b1, 1'b1);
      check("post_rst_tag", 32'(rsp_tag), 32'd0);
      rand_step(1'b0, 1'b1);

      // Tag wrap: request 257 after reset carries tag 0 again.
      do_reset();
      for (int i = 0; i < 257; i++) rand_step(1'b1, 1'b1);
      check("tag_wrap", 32'(rsp_tag), 32'd0);
      rand_step(1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < DEPTH; i++) rand_step(1'b0, 1'b1);
      check("final_empty", 32'(level), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
